// File: rtl/vector_line_engine_pkg.sv
// vector_pkg: shared definitions for the vector line engine.
//   COORD_W  - coordinate width of targets and DAC codes
//   state_t  - engine state encoding (IDLE, SETUP, STEP, SETTLE)
//   point_t  - packed {x, y} coordinate pair
package vector_pkg;

  localparam int COORD_W = 12;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t STEP   = 2'd2;
  localparam state_t SETTLE = 2'd3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/vector_line_engine_if.sv
// vector_line_engine_if: draw command bus between issuer and engine.
//   draw  - command strobe, taken only while ready=1
//   jump  - 1 = blanked move, 0 = visible line
//   x, y  - target coordinates (unsigned)
//   ready - engine idle and able to take a command
// Modports: master (command issuer), slave (engine).
interface vector_line_engine_if;
  import vector_pkg::*;

  logic               draw;
  logic               jump;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               ready;

  modport master (output draw, output jump, output x, output y, input ready);
  modport slave  (input draw, input jump, input x, input y, output ready);

endinterface

// File: rtl/vector_line_engine_step_tick.sv
// step_tick_gen: divides the clock down to one tick every STEP_DIV clocks.
//   clk, reset - clock and async active-high reset
//   restart    - reloads the divider so the next edge is a tick
//   tick       - high on tick edges
module step_tick_gen #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(STEP_DIV);

  logic [CW-1:0] cnt;

  // Down counter: restart parks it at zero so the edge right after a
  // command is accepted is a tick, then every STEP_DIV-th edge after that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= CW'(STEP_DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/vector_line_engine.sv
// vector_line_engine: moves the beam to a commanded target, either as a
// visible Bresenham line (one point per step) or as a blanked jump followed
// by a settle delay, and drives registered X/Y DAC codes plus beam enable.
//   clk, reset  - clock, async active-high reset
//   cmd         - command bus (slave side): draw, jump, x, y, ready
//   x_out/y_out - current beam position (DAC codes)
//   beam_on     - Z/intensity enable
//   point_valid - one-cycle pulse per plotted point
// Optional: define VECTOR_STEP_DIV_EN to slow STEP/SETTLE to one advance
// every STEP_DIV clocks.
module vector_line_engine
  import vector_pkg::*;
#(
  parameter int JUMP_SETTLE = 8
`ifdef VECTOR_STEP_DIV_EN
  , parameter int STEP_DIV = 4
`endif
) (
  input  logic               clk,
  input  logic               reset,
  vector_line_engine_if.slave cmd,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               beam_on,
  output logic               point_valid
);

  localparam int SW = (JUMP_SETTLE < 1) ? 1 : $clog2(JUMP_SETTLE + 1);
  localparam int EW = COORD_W + 3;

  state_t                    state;
  point_t                    tgt;
  logic                      jmp;
  logic                      ready_q;
  logic [COORD_W-1:0]        dx, dy;
  logic                      sx_neg, sy_neg;
  logic signed [COORD_W+1:0] err;
  logic [SW-1:0]             settle;

  logic                      accept;
  logic                      tick;
  logic [COORD_W-1:0]        abs_dx, abs_dy;
  logic signed [EW-1:0]      e2, dx_s, dy_s, err_ext, sub_x, add_y, err_next;
  logic                      step_x, step_y;

  assign accept    = cmd.draw && ready_q;
  assign cmd.ready = ready_q;

`ifdef VECTOR_STEP_DIV_EN
  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign abs_dx = (tgt.x >= x_out) ? (tgt.x - x_out) : (x_out - tgt.x);
  assign abs_dy = (tgt.y >= y_out) ? (tgt.y - y_out) : (y_out - tgt.y);

  // Bresenham decision: both tests use the pre-update error so a diagonal
  // step moves both axes on the same edge.
  always_comb begin
    dx_s     = $signed({3'b000, dx});
    dy_s     = $signed({3'b000, dy});
    err_ext  = $signed({err[COORD_W+1], err});
    e2       = $signed({err, 1'b0});
    step_x   = (e2 > -dy_s);
    step_y   = (e2 < dx_s);
    sub_x    = step_x ? dy_s : $signed({EW{1'b0}});
    add_y    = step_y ? dx_s : $signed({EW{1'b0}});
    err_next = err_ext - sub_x + add_y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      x_out       <= '0;
      y_out       <= '0;
      beam_on     <= 1'b0;
      point_valid <= 1'b0;
      tgt         <= '0;
      jmp         <= 1'b0;
      dx          <= '0;
      dy          <= '0;
      sx_neg      <= 1'b0;
      sy_neg      <= 1'b0;
      err         <= '0;
      settle      <= '0;
    end else begin
      case (state)
        IDLE: begin
          point_valid <= 1'b0;
          if (accept) begin
            tgt     <= '{x: cmd.x, y: cmd.y};
            jmp     <= cmd.jump;
            ready_q <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          dx     <= abs_dx;
          dy     <= abs_dy;
          sx_neg <= (tgt.x < x_out);
          sy_neg <= (tgt.y < y_out);
          err    <= $signed({2'b00, abs_dx}) - $signed({2'b00, abs_dy});
          if (jmp) begin
            x_out   <= tgt.x;
            y_out   <= tgt.y;
            beam_on <= 1'b0;
            settle  <= SW'(JUMP_SETTLE);
            state   <= SETTLE;
          end else begin
            beam_on     <= 1'b1;
            // A zero-length draw is a single dot at the current position.
            point_valid <= (abs_dx == '0) && (abs_dy == '0);
            state       <= STEP;
          end
        end
        STEP: begin
          if (!tick) begin
            point_valid <= 1'b0;
          end else if (x_out == tgt.x && y_out == tgt.y) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            beam_on     <= 1'b0;
            point_valid <= 1'b0;
          end else begin
            if (step_x) x_out <= sx_neg ? x_out - 1'b1 : x_out + 1'b1;
            if (step_y) y_out <= sy_neg ? y_out - 1'b1 : y_out + 1'b1;
            err         <= err_next[COORD_W+1:0];
            point_valid <= 1'b1;
          end
        end
        SETTLE: begin
          if (tick) begin
            if (settle == '0) begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end else begin
              settle <= settle - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_line_engine.sv
// tb_vector_line_engine: self-checking bench for vector_line_engine.
// Expected points come from an ideal rounded-line reference and are queued
// when a command is issued; a monitor pops and compares them on each
// point_valid pulse. Follows the VECTOR_STEP_DIV_EN define of the build.
module tb_vector_line_engine;
  import vector_pkg::*;

  localparam int JUMP_SETTLE = 8;
  localparam int STEP_DIV    = 4;
`ifdef VECTOR_STEP_DIV_EN
  localparam int GAP = STEP_DIV;
`else
  localparam int GAP = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [COORD_W-1:0] x_out, y_out;
  logic               beam_on, point_valid;

  vector_line_engine_if cmd ();

  vector_line_engine #(.JUMP_SETTLE(JUMP_SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd),
    .x_out       (x_out),
    .y_out       (y_out),
    .beam_on     (beam_on),
    .point_valid (point_valid)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  point_t exp_q[$];
  int     cur_x = 0;
  int     cur_y = 0;
  int     cyc = 0;
  int     last_pv = -1;

  typedef struct {
    logic jmp;
    int   tx;
    int   ty;
    int   len;
  } vec_t;

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Edge (counted from the accept edge) on which ready comes back, where n
  // is the line length for draws or the settle count for jumps.
  function automatic int expReadyEdge(input int n);
`ifdef VECTOR_STEP_DIV_EN
    return 1 + (n + 1) * STEP_DIV;
`else
    return n + 2;
`endif
  endfunction

  function automatic int stepEdge(input int k);
`ifdef VECTOR_STEP_DIV_EN
    return 1 + k * STEP_DIV;
`else
    return 1 + k;
`endif
  endfunction

  // Ideal line: the major axis advances one unit per point, the minor axis
  // is the rounded exact position (targets are chosen to avoid .5 ties).
  function automatic void pushLine(input int fx, input int fy, input int tx, input int ty);
    int adx, ady, sgx, sgy, len, px, py;
    point_t p;
    adx = (tx >= fx) ? tx - fx : fx - tx;
    ady = (ty >= fy) ? ty - fy : fy - ty;
    sgx = (tx >= fx) ? 1 : -1;
    sgy = (ty >= fy) ? 1 : -1;
    len = (adx >= ady) ? adx : ady;
    if (len == 0) begin
      p.x = COORD_W'(tx);
      p.y = COORD_W'(ty);
      exp_q.push_back(p);
    end
    for (int k = 1; k <= len; k++) begin
      if (adx >= ady) begin
        px = fx + sgx * k;
        py = fy + sgy * ((2 * k * ady + len) / (2 * len));
      end else begin
        py = fy + sgy * k;
        px = fx + sgx * ((2 * k * adx + len) / (2 * len));
      end
      p.x = COORD_W'(px);
      p.y = COORD_W'(py);
      exp_q.push_back(p);
    end
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    point_t p;
    cyc++;
    if (point_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected point_valid", 1, 0);
      end else begin
        p = exp_q.pop_front();
        checkOutput("point x", int'(x_out), int'(p.x));
        checkOutput("point y", int'(y_out), int'(p.y));
      end
      checkOutput("beam_on at point", int'(beam_on), 1);
      if (last_pv >= 0) checkOutput("point spacing", cyc - last_pv, GAP);
      last_pv = cyc;
    end
    if (cmd.ready || reset) last_pv = -1;
  end

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " ready"}, int'(cmd.ready), 1);
    checkOutput({tag, " x_out"}, int'(x_out), 0);
    checkOutput({tag, " y_out"}, int'(y_out), 0);
    checkOutput({tag, " beam_on"}, int'(beam_on), 0);
    checkOutput({tag, " point_valid"}, int'(point_valid), 0);
  endtask

  // Issues one command and follows it to completion; called just after a
  // rising edge.
  task automatic applyStimulus(input logic jmp, input int tx, input int ty, input int len);
    int w, k;
    w = 0;
    while (!cmd.ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("ready before command", int'(cmd.ready), 1);
    if (!jmp) pushLine(cur_x, cur_y, tx, ty);
    cmd.draw = 1'b1;
    cmd.jump = jmp;
    cmd.x    = COORD_W'(tx);
    cmd.y    = COORD_W'(ty);
    @(posedge clk); #1;
    cmd.draw = 1'b0;
    cmd.jump = ~jmp;
    cmd.x    = ~cmd.x;
    cmd.y    = ~cmd.y;
    checkOutput("ready low after accept", int'(cmd.ready), 0);
    k = 0;
    while (!cmd.ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        if (jmp) begin
          checkOutput("jump x at E1", int'(x_out), tx);
          checkOutput("jump y at E1", int'(y_out), ty);
          checkOutput("jump beam_on", int'(beam_on), 0);
        end else begin
          checkOutput("draw beam_on at E1", int'(beam_on), 1);
        end
      end
    end
    checkOutput("ready return edge", k, expReadyEdge(jmp ? JUMP_SETTLE : len));
    checkOutput("final x_out", int'(x_out), tx);
    checkOutput("final y_out", int'(y_out), ty);
    checkOutput("beam_on after command", int'(beam_on), 0);
    checkOutput("points outstanding", exp_q.size(), 0);
    cur_x = tx;
    cur_y = ty;
  endtask

  initial begin
    vec_t vecs[7];
    int   e;

    vecs[0] = '{jmp: 1'b0, tx: 50, ty: 0,  len: 50};
    vecs[1] = '{jmp: 1'b1, tx: 0,  ty: 0,  len: 0};
    vecs[2] = '{jmp: 1'b0, tx: 5,  ty: 3,  len: 5};
    vecs[3] = '{jmp: 1'b1, tx: 50, ty: 50, len: 0};
    vecs[4] = '{jmp: 1'b0, tx: 50, ty: 0,  len: 50};
    vecs[5] = '{jmp: 1'b0, tx: 50, ty: 0,  len: 0};
    vecs[6] = '{jmp: 1'b0, tx: 46, ty: 7,  len: 7};

    reset    = 1'b0;
    cmd.draw = 1'b0;
    cmd.jump = 1'b0;
    cmd.x    = '0;
    cmd.y    = '0;
    #1 reset = 1'b1;
    #1;
    checkIdleZero("power-on reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].jmp, vecs[i].tx, vecs[i].ty, vecs[i].len);
    end

    // Async reset while idle away from the origin.
    #2 reset = 1'b1;
    #1;
    checkIdleZero("idle reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cur_x = 0;
    cur_y = 0;

    // Long diagonal: a draw while busy is dropped, then reset aborts it.
    pushLine(0, 0, 100, 100);
    cmd.draw = 1'b1;
    cmd.jump = 1'b0;
    cmd.x    = COORD_W'(100);
    cmd.y    = COORD_W'(100);
    @(posedge clk); #1;
    cmd.draw = 1'b0;
    e = 0;
    while (e < stepEdge(5)) begin
      @(posedge clk); #1;
      e++;
    end
    cmd.draw = 1'b1;
    cmd.x    = COORD_W'(7);
    cmd.y    = COORD_W'(7);
    @(posedge clk); #1;
    e++;
    cmd.draw = 1'b0;
    checkOutput("busy draw dropped", int'(cmd.ready), 0);
    while (e < stepEdge(10)) begin
      @(posedge clk); #1;
      e++;
    end
    checkOutput("step 10 x_out", int'(x_out), 10);
    checkOutput("step 10 y_out", int'(y_out), 10);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checkIdleZero("abort reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cur_x = 0;
    cur_y = 0;

    applyStimulus(1'b0, 2, 0, 2);
    applyStimulus(1'b1, 0, 0, 0);
    applyStimulus(1'b0, 3, 0, 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
